// File: rtl/detect_scheduler.sv
// detect_scheduler: round-robin arbiter feeding granted bytes MSB-first through a shared 1-then-0 detector
module detect_scheduler #(
    parameter int NCH = 4,
    parameter int DW = 8,
    parameter int CW = $clog2(DW + 1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*DW-1:0]       data,
    output logic [NCH-1:0]          gnt,
    output logic                    busy,
    output logic                    done,
    output logic [$clog2(NCH)-1:0]  done_id,
    output logic [CW-1:0]           count
);
    localparam int IW = $clog2(NCH);
    localparam int BW = $clog2(DW);

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctl_t;
    typedef enum logic [1:0] {SA, SB, SC} det_t;

    ctl_t state, state_n;
    det_t det, det_n;
    logic [IW-1:0] rr_ptr, id, nxt_ptr, base, sel, cand;
    logic [IW:0] sum;
    logic [DW-1:0] shreg, cur;
    logic [CW-1:0] hits, hits_n;
    logic [BW-1:0] bitcnt;
    logic last, found;

    // The grant decision is made one cycle ahead (idle, or report with the advanced pointer) so gnt can be a register
    always_comb begin
        nxt_ptr = (id == IW'(NCH - 1)) ? '0 : id + 1'b1;
        base = (state == REPORT) ? nxt_ptr : rr_ptr;
        found = 1'b0;
        sel = '0;
        sum = '0;
        cand = '0;
        for (int k = 0; k < NCH; k++) begin
            sum = {1'b0, base} + (IW+1)'(k);
            cand = (sum >= (IW+1)'(NCH)) ? IW'(sum - (IW+1)'(NCH)) : IW'(sum);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel = cand;
            end
        end
        cur = '0;
        for (int i = 0; i < NCH; i++)
            if (id == IW'(i)) cur = data[i*DW +: DW];
        det_n = (det == SA) ? (shreg[DW-1] ? SB : SA) :
                (det == SB) ? (shreg[DW-1] ? SB : SC) :
                              (shreg[DW-1] ? SA : SC);
        hits_n = hits + CW'(det_n == SC);
        last = (bitcnt == BW'(DW - 1));
        state_n = (state == IDLE)  ? ((|gnt) ? SHIFT : IDLE) :
                  (state == SHIFT) ? (last ? REPORT : SHIFT) : IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            det <= SA;
            rr_ptr <= '0;
            id <= '0;
            gnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            done_id <= '0;
            count <= '0;
            shreg <= '0;
            hits <= '0;
            bitcnt <= '0;
        end else begin
            state <= state_n;
            gnt <= '0;
            done <= 1'b0;
            if (state == SHIFT) begin
                det <= det_n;
                shreg <= {shreg[DW-2:0], 1'b0};
                hits <= hits_n;
                bitcnt <= bitcnt + 1'b1;
                if (last) begin
                    done <= 1'b1;
                    done_id <= id;
                    count <= hits_n;
                end
            end else if (state == IDLE && |gnt) begin
                shreg <= cur;
                det <= SA;
                hits <= '0;
                bitcnt <= '0;
            end else begin
                if (state == REPORT) rr_ptr <= nxt_ptr;
                busy <= found;
                if (found) begin
                    gnt <= NCH'(1) << sel;
                    id <= sel;
                end
            end
        end
    end
endmodule

// File: tb/tb_detect_scheduler.sv
// tb_detect_scheduler: directed scenario tests for detect_scheduler with hand-computed results
module tb_detect_scheduler;
    logic CLK, RST;
    logic [3:0] req;
    logic [31:0] data;
    logic [3:0] gnt;
    logic busy, done;
    logic [1:0] done_id;
    logic [3:0] count;
    int pass_cnt = 0;
    int total = 0;

    detect_scheduler #(.NCH(4), .DW(8)) dut (
        .CLK(CLK), .RST(RST), .req(req), .data(data), .gnt(gnt),
        .busy(busy), .done(done), .done_id(done_id), .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        while (gnt == 4'b0 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset;
        RST = 1'b1;
        req = 4'b0;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1;
        req = 4'b1111;
        data = 32'h80808080;
        tick(); tick(); tick();
        total++; if (gnt !== 4'b0) $display("FAIL reset_gnt got %b exp 0000", gnt); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total++; if (done_id !== 2'd0) $display("FAIL reset_done_id got %0d exp 0", done_id); else pass_cnt++;
        total++; if (count !== 4'd0) $display("FAIL reset_count got %0d exp 0", count); else pass_cnt++;
        RST = 1'b0;
        req = 4'b0;
        tick();
        total++; if (gnt !== 4'b0) $display("FAIL reset_release_gnt got %b exp 0000", gnt); else pass_cnt++;
    endtask

    task automatic test_single;
        int n;
        data[7:0] = 8'b1000_0000;
        req = 4'b0001;
        wait_gnt(n);
        total++; if (gnt !== 4'b0001) $display("FAIL single_gnt got %b exp 0001", gnt); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL single_busy_T got %b exp 1", busy); else pass_cnt++;
        req = 4'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            total++; if (busy !== 1'b1) $display("FAIL single_busy_T+%0d got %b exp 1", i, busy); else pass_cnt++;
            total++; if (done !== (i == 9)) $display("FAIL single_done_T+%0d got %b exp %b", i, done, i == 9); else pass_cnt++;
        end
        total++; if (done_id !== 2'd0) $display("FAIL single_done_id got %0d exp 0", done_id); else pass_cnt++;
        total++; if (count !== 4'd7) $display("FAIL single_count got %0d exp 7", count); else pass_cnt++;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL single_busy_after got %b exp 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL single_done_after got %b exp 0", done); else pass_cnt++;
        total++; if (count !== 4'd7) $display("FAIL single_count_held got %0d exp 7", count); else pass_cnt++;
    endtask

    task automatic test_sweep;
        logic [7:0] words [4] = '{8'b0110_0110, 8'b1010_0000, 8'h00, 8'hFF};
        logic [3:0] exp_cnt [4] = '{4'd3, 4'd1, 4'd0, 4'd0};
        int n;
        for (int w = 0; w < 4; w++) begin
            data[23:16] = words[w];
            req = 4'b0100;
            wait_gnt(n);
            total++; if (gnt !== 4'b0100) $display("FAIL sweep%0d_gnt got %b exp 0100", w, gnt); else pass_cnt++;
            req = 4'b0;
            wait_done(n);
            total++; if (done_id !== 2'd2) $display("FAIL sweep%0d_done_id got %0d exp 2", w, done_id); else pass_cnt++;
            total++; if (count !== exp_cnt[w]) $display("FAIL sweep%0d_count got %0d exp %0d", w, count, exp_cnt[w]); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_round_robin;
        int n;
        do_reset();
        data = 32'h80808080;
        req = 4'b1111;
        wait_gnt(n);
        total++; if (gnt !== 4'b0001) $display("FAIL rr_first_gnt got %b exp 0001", gnt); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
                if (done) begin
                    total++; if (done_id !== 2'((k - 1) % 4)) $display("FAIL rr%0d_done_id got %0d exp %0d", k, done_id, (k - 1) % 4); else pass_cnt++;
                end
            end while (gnt == 4'b0 && n < 30);
            total++; if (gnt !== 4'(1 << (k % 4))) $display("FAIL rr%0d_gnt got %b exp %b", k, gnt, 4'(1 << (k % 4))); else pass_cnt++;
            total++; if (n !== 10) $display("FAIL rr%0d_spacing got %0d exp 10", k, n); else pass_cnt++;
        end
        req = 4'b0;
        wait_done(n);
        total++; if (done_id !== 2'd0) $display("FAIL rr_last_done_id got %0d exp 0", done_id); else pass_cnt++;
        tick();
    endtask

    task automatic test_skip;
        int n;
        do_reset();
        data = {8'b1010_0000, 8'h00, 8'h00, 8'b1000_0000};
        req = 4'b0001;
        wait_gnt(n);
        req = 4'b0;
        wait_done(n);
        tick();
        req = 4'b1001;
        wait_gnt(n);
        total++; if (gnt !== 4'b1000) $display("FAIL skip_first_gnt got %b exp 1000", gnt); else pass_cnt++;
        req = 4'b0001;
        tick(); tick(); tick();
        req = 4'b1001;
        wait_done(n);
        total++; if (done_id !== 2'd3) $display("FAIL skip_done_id got %0d exp 3", done_id); else pass_cnt++;
        total++; if (count !== 4'd1) $display("FAIL skip_count got %0d exp 1", count); else pass_cnt++;
        tick();
        total++; if (gnt !== 4'b0001) $display("FAIL skip_second_gnt got %b exp 0001", gnt); else pass_cnt++;
        req = 4'b1000;
        wait_done(n);
        total++; if (count !== 4'd7) $display("FAIL skip_ch0_count got %0d exp 7", count); else pass_cnt++;
        tick();
        total++; if (gnt !== 4'b1000) $display("FAIL skip_third_gnt got %b exp 1000", gnt); else pass_cnt++;
        req = 4'b0;
        wait_done(n);
        tick();
    endtask

    task automatic test_reset_mid;
        int n;
        do_reset();
        data[15:8] = 8'b0110_0110;
        req = 4'b0010;
        wait_gnt(n);
        total++; if (gnt !== 4'b0010) $display("FAIL mid_gnt got %b exp 0010", gnt); else pass_cnt++;
        req = 4'b0;
        tick(); tick(); tick(); tick();
        RST = 1'b1;
        tick();
        total++; if ({gnt, busy, done, done_id, count} !== 12'b0) $display("FAIL mid_outputs got %h exp 000", {gnt, busy, done, done_id, count}); else pass_cnt++;
        req = 4'b0110;
        tick();
        total++; if (gnt !== 4'b0) $display("FAIL mid_gnt_in_reset got %b exp 0000", gnt); else pass_cnt++;
        RST = 1'b0;
        wait_gnt(n);
        total++; if (gnt !== 4'b0010) $display("FAIL mid_regrant got %b exp 0010", gnt); else pass_cnt++;
        req = 4'b0;
        wait_done(n);
        total++; if (done_id !== 2'd1) $display("FAIL mid_done_id got %0d exp 1", done_id); else pass_cnt++;
        total++; if (count !== 4'd3) $display("FAIL mid_count got %0d exp 3", count); else pass_cnt++;
        tick();
    endtask

    task automatic test_churn;
        int n;
        data[7:0] = 8'b1000_0001;
        data[23:16] = 8'b1000_0000;
        req = 4'b0001;
        wait_gnt(n);
        total++; if (gnt !== 4'b0001) $display("FAIL churn_gnt got %b exp 0001", gnt); else pass_cnt++;
        tick(); tick(); tick();
        req = 4'b0;
        wait_done(n);
        req = 4'b0100;
        total++; if (done_id !== 2'd0) $display("FAIL churn_done_id got %0d exp 0", done_id); else pass_cnt++;
        total++; if (count !== 4'd6) $display("FAIL churn_count got %0d exp 6", count); else pass_cnt++;
        tick();
        total++; if (gnt !== 4'b0100) $display("FAIL churn_next_gnt got %b exp 0100", gnt); else pass_cnt++;
        req = 4'b0;
        wait_done(n);
        total++; if (count !== 4'd7) $display("FAIL churn_next_count got %0d exp 7", count); else pass_cnt++;
        tick();
    endtask

    initial begin
        RST = 1'b1;
        req = 4'b0;
        data = '0;
        test_reset();
        test_single();
        test_sweep();
        test_round_robin();
        test_skip();
        test_reset_mid();
        test_churn();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
